legv8_regfile: RTL and testbench

Architectural register file for the lab-5 single-cycle LEGv8 datapath: it is the consumer of the 5-bit register addresses produced by the Reg2Loc read-address select. It provides two asynchronous read ports and one clocked write port, with X31 hardwired as XZR. A sequential dump engine streams all registers out, one per cycle, for board display and bench checking.

---
 rtl/legv8_regfile.sv | 86 ++++++++
 tb/tb_legv8_regfile.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/legv8_regfile.sv
// rtl/legv8_regfile.sv - LEGv8 register file: two async read ports, one write port, XZR at X31, sequential dump engine
module legv8_regfile #(
   parameter int DATA_W = 64,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        read_reg1,
   input  logic [4:0]        read_reg2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic              reg_write,
   input  logic [4:0]        write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              dump_start,
   output logic              dump_valid,
   output logic [4:0]        dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_busy,
   output logic              dump_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [4:0] XZR = 5'd31;

   // X31 has no storage; only X0..X30 are held
   logic [DATA_W-1:0] regs [NREG-1];

   state_t     state, state_next;
   logic [4:0] index, index_next;
   logic       wr_en;

   assign wr_en = reg_write && (write_reg != XZR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG - 1; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[write_reg] <= write_data;
      end
   end

   // A pending write to the addressed register is forwarded in the same cycle
   assign read_data1 = (read_reg1 == XZR) ? '0 :
                       (wr_en && write_reg == read_reg1) ? write_data : regs[read_reg1];
   assign read_data2 = (read_reg2 == XZR) ? '0 :
                       (wr_en && write_reg == read_reg2) ? write_data : regs[read_reg2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         index <= '0;
      end else begin
         state <= state_next;
         index <= index_next;
      end
   end

   always_comb begin
      state_next = state;
      index_next = index;
      case (state)
         IDLE: begin
            if (dump_start) begin
               state_next = RUN;
               index_next = '0;
            end
         end
         RUN: begin
            index_next = index + 5'd1;
            if (index == XZR) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign dump_valid = (state == RUN);
   assign dump_busy  = (state != IDLE);
   assign dump_done  = (state == DONE);
   assign dump_addr  = index;
   assign dump_data  = (!dump_valid || index == XZR) ? '0 :
                       (wr_en && write_reg == index) ? write_data : regs[index];

endmodule

// File: tb/tb_legv8_regfile.sv
// tb/tb_legv8_regfile.sv - directed self-checking bench for legv8_regfile
module tb_legv8_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  read_reg1, read_reg2, write_reg;
   logic [63:0] read_data1, read_data2, write_data, dump_data;
   logic        reg_write, dump_start, dump_valid, dump_busy, dump_done;
   logic [4:0]  dump_addr;

   int passed = 0;
   int total  = 0;

   legv8_regfile #(.DATA_W(64), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(read_data1), .read_data2(read_data2),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
      .dump_start(dump_start), .dump_valid(dump_valid), .dump_addr(dump_addr),
      .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] exp_d;
      rst_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
      read_reg1 = 5'd5; read_reg2 = 5'd0; dump_start = 1'b0;
      #3;
      chk("rst_rd1", read_data1, 64'h0);
      chk("rst_rd2", read_data2, 64'h0);
      chk("rst_valid", {63'b0, dump_valid}, 64'h0);
      chk("rst_busy", {63'b0, dump_busy}, 64'h0);
      chk("rst_done", {63'b0, dump_done}, 64'h0);
      chk("rst_addr", {59'b0, dump_addr}, 64'h0);
      chk("rst_ddata", dump_data, 64'h0);
      #19 rst_n = 1'b1;
      tick();

      // write X5 with bypass, then from storage
      reg_write = 1'b1; write_reg = 5'd5; write_data = 64'hDEAD; read_reg1 = 5'd5;
      #1 chk("x5_bypass", read_data1, 64'hDEAD);
      tick(); reg_write = 1'b0;
      #1 chk("x5_stored", read_data1, 64'hDEAD);

      // XZR
      reg_write = 1'b1; write_reg = 5'd31; write_data = '1; read_reg2 = 5'd31;
      #1 chk("xzr_same", read_data2, 64'h0);
      tick(); reg_write = 1'b0;
      #1 chk("xzr_after", read_data2, 64'h0);
      tick();
      chk("xzr_later", read_data2, 64'h0);

      // bypass over an older value
      reg_write = 1'b1; write_reg = 5'd7; write_data = 64'h10;
      tick(); reg_write = 1'b0; read_reg1 = 5'd7; read_reg2 = 5'd7;
      #1 chk("x7_old", read_data1, 64'h10);
      reg_write = 1'b1; write_data = 64'h22;
      #1 chk("byp_rd1", read_data1, 64'h22);
      chk("byp_rd2", read_data2, 64'h22);
      tick(); reg_write = 1'b0;
      #1 chk("byp_keep1", read_data1, 64'h22);
      chk("byp_keep2", read_data2, 64'h22);

      // write-enable gating
      reg_write = 1'b0; write_reg = 5'd3; write_data = 64'h99; read_reg1 = 5'd3;
      #1 chk("gate_same", read_data1, 64'h0);
      tick();
      chk("gate_after", read_data1, 64'h0);

      // load Xi = i+1
      for (int i = 0; i < 31; i++) begin
         reg_write = 1'b1; write_reg = 5'(i); write_data = 64'(i + 1);
         tick();
      end
      reg_write = 1'b0; read_reg1 = 5'd0; read_reg2 = 5'd30;
      #1 chk("load_x0", read_data1, 64'd1);
      chk("load_x30", read_data2, 64'd31);

      // full dump; second start at beat 5 ignored; bypass write at beat 12
      dump_start = 1'b1;
      #1 chk("dump_idle_valid", {63'b0, dump_valid}, 64'h0);
      tick();
      dump_start = 1'b0;
      for (int b = 0; b < 32; b++) begin
         dump_start = (b == 5);
         reg_write = (b == 12); write_reg = 5'd12; write_data = 64'h77;
         exp_d = (b == 31) ? 64'h0 : (b == 12) ? 64'h77 : 64'(b + 1);
         #1;
         chk($sformatf("beat%0d_valid", b), {63'b0, dump_valid}, 64'h1);
         chk($sformatf("beat%0d_addr", b), {59'b0, dump_addr}, 64'(b));
         chk($sformatf("beat%0d_data", b), dump_data, exp_d);
         chk($sformatf("beat%0d_busy", b), {63'b0, dump_busy}, 64'h1);
         chk($sformatf("beat%0d_done", b), {63'b0, dump_done}, 64'h0);
         tick();
      end
      dump_start = 1'b0; reg_write = 1'b0;
      #1 chk("done_pulse", {63'b0, dump_done}, 64'h1);
      chk("done_busy", {63'b0, dump_busy}, 64'h1);
      chk("done_valid", {63'b0, dump_valid}, 64'h0);
      tick();
      chk("idle_done", {63'b0, dump_done}, 64'h0);
      chk("idle_busy", {63'b0, dump_busy}, 64'h0);
      chk("idle_valid", {63'b0, dump_valid}, 64'h0);
      read_reg1 = 5'd12;
      #1 chk("x12_written", read_data1, 64'h77);

      // reset mid-dump
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      for (int b = 0; b < 10; b++) tick();
      chk("mid_addr", {59'b0, dump_addr}, 64'd10);
      chk("mid_data", dump_data, 64'd11);
      rst_n = 1'b0;
      #1 chk("abort_valid", {63'b0, dump_valid}, 64'h0);
      chk("abort_busy", {63'b0, dump_busy}, 64'h0);
      chk("abort_done", {63'b0, dump_done}, 64'h0);
      chk("abort_addr", {59'b0, dump_addr}, 64'h0);
      read_reg1 = 5'd12; read_reg2 = 5'd30;
      #1 chk("abort_rd1", read_data1, 64'h0);
      chk("abort_rd2", read_data2, 64'h0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("post_done%0d", c), {63'b0, dump_done}, 64'h0);
         chk($sformatf("post_busy%0d", c), {63'b0, dump_busy}, 64'h0);
      end
      read_reg1 = 5'd0;
      #1 chk("post_x0", read_data1, 64'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
